frame_sync_controller: RTL and testbench

Sequences the per-frame handshake between the game CPU and the VGA display path. Debounces the jump button, raises `screen_ready` once per vertical blank, double-buffers the CPU-written dino/obstacle coordinates so the display only changes at vsync, and latches collisions into a game-over state. Sits between the CPU wrapper's register ports and the VGA controller, clocked from the 100 MHz system clock.

---
 rtl/dino_pkg.sv | 23 ++
 rtl/button_debouncer.sv | 59 +++++
 rtl/frame_sync_controller.sv | 193 +++++++++++++++++++
 tb/tb_frame_sync_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game frame path.
// Provides the game/frame state encodings and default bus widths used by
// frame_sync_controller and its testbench.
package dino_pkg;

  // Default coordinate bus width and committed-frame counter width.
  localparam int unsigned COORD_W_DEFAULT = 32;
  localparam int unsigned FRAME_CNT_W     = 16;

  // Top-level game mode; encoding is visible on the game_state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_e;

  // Per-frame handshake phase while the game is running.
  typedef enum logic {
    PEND  = 1'b0,
    READY = 1'b1
  } frame_state_e;

endpackage : dino_pkg

// File: rtl/button_debouncer.sv
// Jump-button conditioner: 2-flop synchronizer, level debouncer, rising-edge
// detector.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   button_raw raw pushbutton level, asynchronous to clk
//   press_evt  registered one-cycle pulse on an accepted 0->1 level change
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic press_evt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept the synchronized level once it has differed from the accepted
  // level for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        evt_d    = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      evt_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= button_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      evt_q    <= evt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_evt = evt_q;

endmodule : button_debouncer

// File: rtl/frame_sync_controller.sv
// Per-frame handshake between the game CPU and the VGA display path.
// Debounces the jump button, tells the CPU when it may compute the next
// frame, double-buffers CPU coordinates so the display only changes at
// vsync, and latches collisions into a game-over state.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   button_raw                 raw jump button
//   vsync_start                one-cycle pulse at start of vertical blank
//   collision_raw              pixel-level overlap from the VGA path
//   cpu_x/y, cpu_x/y_obs       CPU-written dino/obstacle coordinates
//   cpu_frame_done             one-cycle pulse, CPU finished this frame
//   button_press               debounced press, sticky until next commit
//   screen_ready               CPU may compute the next frame
//   collision_detected         sticky collision flag
//   disp_x/y, disp_x/y_obs     committed coordinates to VGA
//   game_state                 IDLE/RUN/OVER
//   frame_count                committed frames since last restart
//   overrun                    sticky, vsync arrived before cpu_frame_done
module frame_sync_controller
  import dino_pkg::*;
#(
  parameter int unsigned COORD_W         = COORD_W_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DINO_X0         = 100,
  parameter int unsigned DINO_Y0         = 400,
  parameter int unsigned OBS_X0          = 640,
  parameter int unsigned OBS_Y0          = 400
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   button_raw,
  input  logic                   vsync_start,
  input  logic                   collision_raw,
  input  logic [COORD_W-1:0]     cpu_x,
  input  logic [COORD_W-1:0]     cpu_y,
  input  logic [COORD_W-1:0]     cpu_x_obs,
  input  logic [COORD_W-1:0]     cpu_y_obs,
  input  logic                   cpu_frame_done,
  output logic                   button_press,
  output logic                   screen_ready,
  output logic                   collision_detected,
  output logic [COORD_W-1:0]     disp_x,
  output logic [COORD_W-1:0]     disp_y,
  output logic [COORD_W-1:0]     disp_x_obs,
  output logic [COORD_W-1:0]     disp_y_obs,
  output logic [1:0]             game_state,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   overrun
);

  localparam logic [COORD_W-1:0] DINO_X_INIT = COORD_W'(DINO_X0);
  localparam logic [COORD_W-1:0] DINO_Y_INIT = COORD_W'(DINO_Y0);
  localparam logic [COORD_W-1:0] OBS_X_INIT  = COORD_W'(OBS_X0);
  localparam logic [COORD_W-1:0] OBS_Y_INIT  = COORD_W'(OBS_Y0);

  logic press_evt;

  game_state_e            game_q;
  frame_state_e           frame_q;
  logic                   ready_q;
  logic                   press_q;
  logic                   coll_q;
  logic                   overrun_q;
  logic [FRAME_CNT_W-1:0] count_q;
  logic [COORD_W-1:0]     disp_x_q, disp_y_q, disp_xo_q, disp_yo_q;
  logic [COORD_W-1:0]     shad_x_q, shad_y_q, shad_xo_q, shad_yo_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debouncer (
    .clk        (clk),
    .reset      (reset),
    .button_raw (button_raw),
    .press_evt  (press_evt)
  );

  // Game and frame sequencing; later assignments in the block take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      game_q    <= IDLE;
      frame_q   <= PEND;
      ready_q   <= 1'b0;
      press_q   <= 1'b0;
      coll_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
      disp_x_q  <= DINO_X_INIT;
      disp_y_q  <= DINO_Y_INIT;
      disp_xo_q <= OBS_X_INIT;
      disp_yo_q <= OBS_Y_INIT;
      shad_x_q  <= '0;
      shad_y_q  <= '0;
      shad_xo_q <= '0;
      shad_yo_q <= '0;
    end else begin
      unique case (game_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (press_evt) begin
            game_q  <= RUN;
            frame_q <= PEND;
            ready_q <= 1'b1;
          end
        end

        RUN: begin
          if (collision_raw) begin
            coll_q <= 1'b1;
          end
          unique case (frame_q)
            PEND: begin
              ready_q <= 1'b1;
              if (vsync_start && cpu_frame_done) begin
                // CPU finished exactly at vsync: bypass the shadow.
                disp_x_q  <= cpu_x;
                disp_y_q  <= cpu_y;
                disp_xo_q <= cpu_x_obs;
                disp_yo_q <= cpu_y_obs;
                count_q   <= count_q + FRAME_CNT_W'(1);
                press_q   <= 1'b0;
              end else if (cpu_frame_done) begin
                shad_x_q  <= cpu_x;
                shad_y_q  <= cpu_y;
                shad_xo_q <= cpu_x_obs;
                shad_yo_q <= cpu_y_obs;
                frame_q   <= READY;
                ready_q   <= 1'b0;
              end else if (vsync_start) begin
                overrun_q <= 1'b1;
              end
            end
            READY: begin
              ready_q <= 1'b0;
              if (vsync_start) begin
                disp_x_q  <= shad_x_q;
                disp_y_q  <= shad_y_q;
                disp_xo_q <= shad_xo_q;
                disp_yo_q <= shad_yo_q;
                count_q   <= count_q + FRAME_CNT_W'(1);
                press_q   <= 1'b0;
                frame_q   <= PEND;
                ready_q   <= 1'b1;
              end
            end
          endcase
          // Game over only at vsync, so the colliding frame is fully shown.
          if (vsync_start && coll_q) begin
            game_q  <= OVER;
            ready_q <= 1'b0;
          end
        end

        OVER: begin
          ready_q <= 1'b0;
          if (press_evt) begin
            game_q    <= IDLE;
            frame_q   <= PEND;
            coll_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
            press_q   <= 1'b0;
            disp_x_q  <= DINO_X_INIT;
            disp_y_q  <= DINO_Y_INIT;
            disp_xo_q <= OBS_X_INIT;
            disp_yo_q <= OBS_Y_INIT;
          end
        end

        default: begin
          game_q  <= IDLE;
          ready_q <= 1'b0;
        end
      endcase

      // A press in any state sets the sticky flag, overriding any clear.
      if (press_evt) begin
        press_q <= 1'b1;
      end
    end
  end

  assign button_press       = press_q;
  assign screen_ready       = ready_q;
  assign collision_detected = coll_q;
  assign disp_x             = disp_x_q;
  assign disp_y             = disp_y_q;
  assign disp_x_obs         = disp_xo_q;
  assign disp_y_obs         = disp_yo_q;
  assign game_state         = game_q;
  assign frame_count        = count_q;
  assign overrun            = overrun_q;

endmodule : frame_sync_controller

// File: tb/tb_frame_sync_controller.sv
// Testbench for frame_sync_controller: directed test-plan steps followed by
// randomized traffic, checked every cycle against a behavioural model.
module tb_frame_sync_controller;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          button_raw = 1'b0;
  logic          vsync_start = 1'b0;
  logic          collision_raw = 1'b0;
  logic [CW-1:0] cpu_x = '0, cpu_y = '0, cpu_x_obs = '0, cpu_y_obs = '0;
  logic          cpu_frame_done = 1'b0;
  logic          button_press, screen_ready, collision_detected, overrun;
  logic [CW-1:0] disp_x, disp_y, disp_x_obs, disp_y_obs;
  logic [1:0]    game_state;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  frame_sync_controller #(
    .COORD_W         (CW),
    .DEBOUNCE_CYCLES (DB),
    .DINO_X0         (100),
    .DINO_Y0         (400),
    .OBS_X0          (640),
    .OBS_Y0          (400)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .button_raw         (button_raw),
    .vsync_start        (vsync_start),
    .collision_raw      (collision_raw),
    .cpu_x              (cpu_x),
    .cpu_y              (cpu_y),
    .cpu_x_obs          (cpu_x_obs),
    .cpu_y_obs          (cpu_y_obs),
    .cpu_frame_done     (cpu_frame_done),
    .button_press       (button_press),
    .screen_ready       (screen_ready),
    .collision_detected (collision_detected),
    .disp_x             (disp_x),
    .disp_y             (disp_y),
    .disp_x_obs         (disp_x_obs),
    .disp_y_obs         (disp_y_obs),
    .game_state         (game_state),
    .frame_count        (frame_count),
    .overrun            (overrun)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model. Button history holds raw levels seen at past edges; the
  // last two are still inside the synchronizer, the older DB decide acceptance.
  bit          hist[$];
  bit          lvl = 1'b0;
  bit          evt_pend = 1'b0;
  int          mode = 0;          // 0 idle, 1 running, 2 game over
  bit          have_frame = 1'b0; // CPU frame waiting for vsync
  logic [31:0] sx, sy, sxo, syo;
  logic        e_bp = 0, e_sr = 0, e_col = 0, e_ovr = 0;
  logic [31:0] e_dx = 100, e_dy = 400, e_dxo = 640, e_dyo = 400;
  logic [15:0] e_fc = 0;

  int btn_left = 0;
  bit btn_lvl = 1'b0;

  task automatic go_home();
    e_dx = 100; e_dy = 400; e_dxo = 640; e_dyo = 400;
  endtask

  task automatic model_edge();
    bit accept;
    bit evt;
    bit col_was;
    bit commit;
    if (reset) begin
      hist.delete();
      for (int i = 0; i < int'(DB) + 2; i++) hist.push_back(1'b0);
      lvl = 0; evt_pend = 0; mode = 0; have_frame = 0;
      e_bp = 0; e_sr = 0; e_col = 0; e_ovr = 0; e_fc = 0;
      go_home();
    end else begin
      evt = evt_pend;
      hist.push_back(button_raw);
      if (hist.size() > int'(DB) + 2) void'(hist.pop_front());
      accept = 1'b1;
      for (int k = 0; k < int'(DB); k++) if (hist[k] == lvl) accept = 1'b0;
      evt_pend = accept && !lvl;
      if (accept) lvl = !lvl;

      commit = 1'b0;
      if (mode == 0) begin
        e_sr = 0;
        if (evt) begin mode = 1; have_frame = 0; e_sr = 1; end
      end else if (mode == 1) begin
        col_was = e_col;
        if (collision_raw) e_col = 1;
        if (!have_frame) begin
          e_sr = 1;
          if (vsync_start && cpu_frame_done) begin
            e_dx = cpu_x; e_dy = cpu_y; e_dxo = cpu_x_obs; e_dyo = cpu_y_obs;
            commit = 1'b1;
          end else if (cpu_frame_done) begin
            sx = cpu_x; sy = cpu_y; sxo = cpu_x_obs; syo = cpu_y_obs;
            have_frame = 1; e_sr = 0;
          end else if (vsync_start) begin
            e_ovr = 1;
          end
        end else if (vsync_start) begin
          e_dx = sx; e_dy = sy; e_dxo = sxo; e_dyo = syo;
          have_frame = 0; e_sr = 1; commit = 1'b1;
        end
        if (commit) begin e_fc = e_fc + 16'd1; e_bp = 0; end
        if (vsync_start && col_was) begin mode = 2; e_sr = 0; end
      end else begin
        e_sr = 0;
        if (evt) begin
          mode = 0; e_col = 0; e_ovr = 0; e_fc = 0; e_bp = 0;
          go_home();
        end
      end
      if (evt) e_bp = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    check("button_press", 32'(button_press), 32'(e_bp));
    check("screen_ready", 32'(screen_ready), 32'(e_sr));
    check("collision_detected", 32'(collision_detected), 32'(e_col));
    check("overrun", 32'(overrun), 32'(e_ovr));
    check("game_state", 32'(game_state), 32'(mode));
    check("frame_count", 32'(frame_count), 32'(e_fc));
    check("disp_x", disp_x, e_dx);
    check("disp_y", disp_y, e_dy);
    check("disp_x_obs", disp_x_obs, e_dxo);
    check("disp_y_obs", disp_y_obs, e_dyo);
  endtask

  // One clock: drive on the falling edge, model the rising edge, sample after it.
  task automatic step(input logic rst, input logic b, input logic vs, input logic dn,
                      input logic cl);
    @(negedge clk);
    reset = rst; button_raw = b; vsync_start = vs; cpu_frame_done = dn; collision_raw = cl;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  initial begin
    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_game_state", 32'(game_state), 32'd0);
    check("rst_disp_x", disp_x, 32'd100);
    check("rst_disp_x_obs", disp_x_obs, 32'd640);

    // Press held: accepted 2 + DB + 1 cycles after the edge.
    repeat (6) step(0, 1, 0, 0, 0);
    check("press_early", 32'(button_press), 32'd0);
    step(0, 1, 0, 0, 0);
    check("press_cycle7", 32'(button_press), 32'd1);
    check("run_state", 32'(game_state), 32'd1);
    check("run_ready", 32'(screen_ready), 32'd1);
    step(0, 1, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);

    // Normal frame commit through the shadow.
    cpu_x = 150; cpu_y = 410; cpu_x_obs = 600; cpu_y_obs = 405;
    step(0, 0, 0, 1, 0);
    check("done_ready_low", 32'(screen_ready), 32'd0);
    repeat (20) step(0, 0, 0, 0, 0);
    check("disp_x_hold", disp_x, 32'd100);
    cpu_x = 777;
    step(0, 0, 1, 0, 0);
    check("disp_x_commit", disp_x, 32'd150);
    check("count_one", 32'(frame_count), 32'd1);

    // Vsync with no frame ready: overrun.
    step(0, 0, 1, 0, 0);
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_disp", disp_x, 32'd150);
    check("overrun_count", 32'(frame_count), 32'd1);

    // Frame done coincident with vsync: direct commit.
    cpu_y = 380;
    step(0, 0, 1, 1, 0);
    check("bypass_disp_y", disp_y, 32'd380);
    check("bypass_count", 32'(frame_count), 32'd2);
    check("bypass_ready", 32'(screen_ready), 32'd1);

    // Collision pulse, game over at next vsync.
    step(0, 0, 0, 0, 1);
    check("coll_set", 32'(collision_detected), 32'd1);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("coll_still_run", 32'(game_state), 32'd1);
    step(0, 0, 1, 0, 0);
    check("game_over", 32'(game_state), 32'd2);
    cpu_x = 5;
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    check("over_frozen", 32'(frame_count), 32'(e_fc));

    // Short glitch ignored, then a real press restarts.
    repeat (2) step(0, 1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    check("glitch_state", 32'(game_state), 32'd2);
    repeat (8) step(0, 1, 0, 0, 0);
    check("restart_state", 32'(game_state), 32'd0);
    check("restart_disp_y_obs", disp_y_obs, 32'd400);
    check("restart_count", 32'(frame_count), 32'd0);
    check("restart_coll", 32'(collision_detected), 32'd0);
    repeat (6) step(0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (btn_left == 0) begin
        btn_lvl = ~btn_lvl;
        btn_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(5, 40));
      end
      btn_left--;
      cpu_x = $urandom_range(0, 1023);
      cpu_y = $urandom_range(0, 1023);
      cpu_x_obs = $urandom;
      cpu_y_obs = $urandom;
      step(1'($urandom_range(0, 799) == 0), btn_lvl,
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_frame_sync_controller
